traffic_light_controller_param: RTL
===================================

Name: traffic_light_controller_param

Overview:
- Parametrised two-road intersection controller (main road plus side road) with configurable phase durations, a tick prescaler, a latched pedestrian walk phase and a flashing-amber override mode.
- Drives both road signal heads and a pedestrian walk lamp.
- Sits between the timing/sensor front end and the lamp drivers.

Parameters:
- PRESCALE, 1, clk cycles per timing tick (>=1; 1 = tick every cycle)
- GREEN_TICKS, 5, ticks per green phase (>=1)
- YELLOW_TICKS, 3, ticks per yellow phase (>=1)
- ALL_RED_TICKS, 1, ticks per all-red clearance phase (>=1)
- PED_TICKS, 4, ticks per pedestrian walk phase (>=1)
- CNT_W, 8, phase counter width; must hold max(*_TICKS)-1

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- ped_req  input  1  pedestrian request, sampled every clk, pulse or level
- flash_mode  input  1  synchronous level; 1 = flashing override
- main_light  output  3  {red,green,yellow}: 100 red, 010 green, 001 yellow, 000 dark
- side_light  output  3  same encoding as main_light
- ped_walk  output  1  walk lamp
- ped_pending  output  1  request latched, not yet served
- phase  output  3  current state encoding

Behaviour:
- One clock; reset is asynchronous and active-low.
- On rst_n=0, immediately:
  - state AR_B
  - phase counter 0
  - prescaler 0
  - blink 0
  - ped_pending 0
  - outputs: main_light=100, side_light=100, ped_walk=0, phase=5
- Tick: the prescaler counts 0..PRESCALE-1; tick=1 on the cycle it equals PRESCALE-1, then it wraps to 0. The prescaler free-runs and is never cleared except by reset.
- Phase counter:
  - Cleared on every state entry.
  - On a tick: if counter == DUR-1, transition and clear; else increment.
  - Each phase therefore lasts DUR*PRESCALE cycles, except the first phase after reset or after a flash exit, which can be shorter by up to PRESCALE-1 cycles.
- States (phase code): main light / side light / ped_walk / duration
  - MG (0): 010 / 100 / 0 / GREEN_TICKS
  - MY (1): 001 / 100 / 0 / YELLOW_TICKS
  - AR_A (2): 100 / 100 / 0 / ALL_RED_TICKS
  - PW (3): 100 / 100 / 1 / PED_TICKS
  - SG (4): 100 / 010 / 0 / GREEN_TICKS
  - AR_B (5): 100 / 100 / 0 / ALL_RED_TICKS
  - SY (6): 100 / 001 / 0 / YELLOW_TICKS
  - FL (7): flashing override, see below
- Sequence:
  - MG -> MY -> AR_A
  - AR_A -> PW if ped_pending=1 at the transition, else AR_A -> SG
  - PW -> SG -> SY -> AR_B -> MG
- Outputs are Moore-decoded from registered state and change on the same edge as the state.
- ped_pending:
  - Set on any cycle where ped_req=1 and the state is not PW and not entering PW.
  - Cleared on the edge entering PW.
  - Requests during PW, or on the entry cycle, are dropped.
  - Requests during MY or AR_A before the AR_A exit are served in the same cycle of the sequence.
- Flash override (priority: rst_n > flash_mode > normal sequencing):
  - flash_mode=1 in any non-FL state: next edge enters FL, counter cleared, blink cleared, ped_pending cleared.
  - In FL: blink toggles on each tick. main_light = blink ? 001 : 000; side_light = blink ? 100 : 000; ped_walk=0. ped_req is ignored.
  - flash_mode=0 while in FL: next edge enters AR_B (counter 0), then MG.
- The counter and prescaler never overflow by construction.
- Any illegal state code decodes as AR_B on the next edge.

Test Plan:
- Default parameters overridden to PRESCALE=1, GREEN=4, YELLOW=2, ALL_RED=1, PED=3.
  1. Release reset, no requests -> AR_B 1 cycle, MG 4, MY 2, AR_A 1, SG 4, SY 2, AR_B 1; period 14 cycles, repeats; both lights never non-red at once.
  2. ped_req 1-cycle pulse during MG -> ped_pending=1 next cycle; after AR_A, PW for 3 cycles with ped_walk=1 and lights 100/100; ped_pending=0 from PW entry; then SG.
  3. ped_req held high through PW -> not re-latched during PW; re-latched from the first SG cycle, served in the next cycle.
  4. flash_mode asserted mid-SG -> FL next cycle, phase=7; main_light alternates 000/001 and side_light 000/100 each cycle. Deassert -> AR_B 1 cycle, then MG for 4.
  5. rst_n pulled low mid-PW (asynchronous, between edges) -> immediately main=100, side=100, ped_walk=0, ped_pending=0, phase=5.
  6. PRESCALE=3, GREEN=4 -> steady-state MG lasts exactly 12 cycles; MY lasts 6.

Source files
------------

// File: rtl/traffic_light_controller_param.sv
// Two-road intersection controller: main/side signal heads, latched pedestrian walk phase,
// tick prescaler for phase timing and a flashing-amber override.
module traffic_light_controller_param #(
    parameter int PRESCALE      = 1,
    parameter int GREEN_TICKS   = 5,
    parameter int YELLOW_TICKS  = 3,
    parameter int ALL_RED_TICKS = 1,
    parameter int PED_TICKS     = 4,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ped_req,
    input  logic       flash_mode,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       ped_walk,
    output logic       ped_pending,
    output logic [2:0] phase
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_GREEN  = 3'b010;
    localparam logic [2:0] LAMP_YELLOW = 3'b001;
    localparam logic [2:0] LAMP_DARK   = 3'b000;

    typedef enum logic [2:0] {
        S_MG   = 3'd0,
        S_MY   = 3'd1,
        S_AR_A = 3'd2,
        S_PW   = 3'd3,
        S_SG   = 3'd4,
        S_AR_B = 3'd5,
        S_SY   = 3'd6,
        S_FL   = 3'd7
    } state_t;

    state_t            state_q, state_d;
    state_t            succ_state;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  dur_m1;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic              blink_q, blink_d;
    logic              pend_q, pend_d;
    logic              tick;
    logic              phase_done;

    // Free-running prescaler; only reset ever clears it.
    assign tick  = (pre_q == PRE_W'(PRESCALE - 1));
    assign pre_d = tick ? '0 : pre_q + 1'b1;

    always_comb begin
        dur_m1 = '0;
        case (state_q)
            S_MG, S_SG:     dur_m1 = CNT_W'(GREEN_TICKS - 1);
            S_MY, S_SY:     dur_m1 = CNT_W'(YELLOW_TICKS - 1);
            S_AR_A, S_AR_B: dur_m1 = CNT_W'(ALL_RED_TICKS - 1);
            S_PW:           dur_m1 = CNT_W'(PED_TICKS - 1);
            default:        dur_m1 = '0;
        endcase
    end

    assign phase_done = (cnt_q == dur_m1);

    // The walk phase is inserted only if a request was already latched when AR_A expires.
    always_comb begin
        succ_state = S_AR_B;
        case (state_q)
            S_MG:    succ_state = S_MY;
            S_MY:    succ_state = S_AR_A;
            S_AR_A:  succ_state = pend_q ? S_PW : S_SG;
            S_PW:    succ_state = S_SG;
            S_SG:    succ_state = S_SY;
            S_SY:    succ_state = S_AR_B;
            S_AR_B:  succ_state = S_MG;
            default: succ_state = S_AR_B;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_AR_B;
            cnt_q   <= '0;
            pre_q   <= '0;
            blink_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            blink_q <= blink_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        blink_d = blink_q;
        if (state_q != S_FL && flash_mode) begin
            state_d = S_FL;
            cnt_d   = '0;
            blink_d = 1'b0;
        end else begin
            case (state_q)
                S_FL: begin
                    if (!flash_mode) begin
                        state_d = S_AR_B;
                        cnt_d   = '0;
                    end else if (tick) begin
                        blink_d = ~blink_q;
                    end
                end
                S_MG, S_MY, S_AR_A, S_PW, S_SG, S_AR_B, S_SY: begin
                    if (tick) begin
                        if (phase_done) begin
                            state_d = succ_state;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = S_AR_B;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Requests are dropped while walking, on the walk entry edge and throughout flashing.
    always_comb begin
        pend_d = pend_q;
        if (state_d == S_FL) begin
            pend_d = 1'b0;
        end else if (state_q == S_FL) begin
            pend_d = pend_q;
        end else if (state_d == S_PW && state_q != S_PW) begin
            pend_d = 1'b0;
        end else if (ped_req && state_q != S_PW) begin
            pend_d = 1'b1;
        end
    end

    always_comb begin
        main_light = LAMP_RED;
        side_light = LAMP_RED;
        ped_walk   = 1'b0;
        case (state_q)
            S_MG:    main_light = LAMP_GREEN;
            S_MY:    main_light = LAMP_YELLOW;
            S_PW:    ped_walk   = 1'b1;
            S_SG:    side_light = LAMP_GREEN;
            S_SY:    side_light = LAMP_YELLOW;
            S_FL: begin
                main_light = blink_q ? LAMP_YELLOW : LAMP_DARK;
                side_light = blink_q ? LAMP_RED : LAMP_DARK;
            end
            default: begin
                main_light = LAMP_RED;
                side_light = LAMP_RED;
            end
        endcase
    end

    assign ped_pending = pend_q;
    assign phase       = state_q;

endmodule
